// File: rtl/keypad_events.sv
// -----------------------------------------------------------------------------
// keypad_events
//
// Turns a raw, asynchronous key matrix into clean key levels, a queue of
// press/release events and a "wait for key" helper for Fx0A-style
// instructions.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   keypad_matrix  raw key lines, 1 = pressed (asynchronous)
//   key_state      debounced key levels
//   any_pressed    OR of the debounced key levels
//   evt_valid      event FIFO head is valid
//   evt_ready      consumer pops the head when evt_valid & evt_ready
//   evt_index      head key index
//   evt_is_press   head type: 1 = press, 0 = release
//   wait_req       one-cycle pulse that arms (or re-arms) the wait unit
//   wait_busy      wait unit armed
//   wait_done      one-cycle completion pulse
//   wait_index     captured key, held until the next capture
//   overflow       sticky lost-event flag
//   clear_overflow clears overflow (a simultaneous new loss wins)
// -----------------------------------------------------------------------------
module keypad_events #(
    parameter int NUM_KEYS        = 16,
    parameter int IDX_W           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DB_W            = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int WAIT_ON_RELEASE = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keypad_matrix,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                any_pressed,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_index,
    output logic                evt_is_press,
    input  logic                wait_req,
    output logic                wait_busy,
    output logic                wait_done,
    output logic [IDX_W-1:0]    wait_index,
    output logic                overflow,
    input  logic                clear_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = IDX_W + 1;
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    // -------------------------------------------------------------------------
    // Per-key synchroniser and debouncer. level_reg is the debounced level;
    // key_state is a registered copy of it one cycle later, so the edge at
    // which key_state changes is visible combinationally as level != state.
    // -------------------------------------------------------------------------
    logic [NUM_KEYS-1:0] db_level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= keypad_matrix[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg >= DB_LAST) begin
                        level_reg <= ~level_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign db_level[gi] = level_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Key state, pending event bits, arbiter and overflow
    // -------------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_state_reg;
    logic                any_pressed_reg;
    logic [NUM_KEYS-1:0] pend_press_reg,   pend_press_next;
    logic [NUM_KEYS-1:0] pend_release_reg, pend_release_next;
    logic                overflow_reg,     overflow_next;

    logic [NUM_KEYS-1:0] rise, fall, pend_any;
    logic [NUM_KEYS-1:0] sel_onehot, clr_press, clr_release;
    logic                sel_found, sel_press;
    logic [IDX_W-1:0]    sel_idx;
    logic                lost;

    // FIFO state
    logic [ENT_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next, count_after_pop;
    logic             evt_valid_reg;
    logic [IDX_W-1:0] evt_index_reg;
    logic             evt_is_press_reg;
    logic [ENT_W-1:0] push_entry, head_next;
    logic             fifo_full, push, pop;

    assign rise     = db_level & ~key_state_reg;
    assign fall     = ~db_level & key_state_reg;
    assign pend_any = pend_press_reg | pend_release_reg;

    // Lowest index with anything pending wins; press before release.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_press = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_any[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_press = pend_press_reg[i];
            end
        end
    end

    assign pop        = evt_valid_reg & evt_ready;
    assign fifo_full  = (count_reg == FIFO_FULL);
    assign push       = sel_found & (~fifo_full | pop);
    assign push_entry = {sel_idx, sel_press};

    always_comb begin
        sel_onehot  = push ? (NUM_KEYS'(1) << sel_idx) : '0;
        clr_press   = sel_press ? sel_onehot : '0;
        clr_release = sel_press ? '0 : sel_onehot;

        pend_press_next   = (pend_press_reg & ~clr_press) | rise;
        pend_release_next = (pend_release_reg & ~clr_release) | fall;

        // A bit that is being drained this very cycle can take the new edge,
        // so only a bit that stays set counts as a lost event.
        lost = (|(rise & pend_press_reg & ~clr_press)) |
               (|(fall & pend_release_reg & ~clr_release));

        overflow_next = lost | (overflow_reg & ~clear_overflow);
    end

    // FIFO next-state. The head registers are loaded with whatever entry will
    // sit at the read pointer after this edge; an entry pushed into an empty
    // queue bypasses the storage array.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CNT_W'(1);
        end

        rd_ptr_next     = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
        count_after_pop = pop ? (count_reg - CNT_W'(1)) : count_reg;

        head_next = {evt_index_reg, evt_is_press_reg};
        if (count_after_pop != '0) begin
            head_next = mem_reg[rd_ptr_next];
        end else if (push) begin
            head_next = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_state_reg    <= '0;
            any_pressed_reg  <= 1'b0;
            pend_press_reg   <= '0;
            pend_release_reg <= '0;
            overflow_reg     <= 1'b0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            evt_valid_reg    <= 1'b0;
            evt_index_reg    <= '0;
            evt_is_press_reg <= 1'b0;
        end else begin
            key_state_reg    <= db_level;
            any_pressed_reg  <= |db_level;
            pend_press_reg   <= pend_press_next;
            pend_release_reg <= pend_release_next;
            overflow_reg     <= overflow_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            evt_valid_reg    <= (count_next != '0);
            evt_index_reg    <= head_next[ENT_W-1:1];
            evt_is_press_reg <= head_next[0];
        end
    end

    // -------------------------------------------------------------------------
    // Wait-for-key unit. It watches key_state edges (one cycle after they
    // happen), so completion pulses on the edge after the qualifying change.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ARMED = 2'd1,
        W_HELD  = 2'd2
    } wait_state_t;

    wait_state_t         wait_state_reg;
    logic                wait_busy_reg;
    logic                wait_done_reg;
    logic [IDX_W-1:0]    wait_index_reg;
    logic [NUM_KEYS-1:0] key_prev_reg;
    logic [NUM_KEYS-1:0] wrise, wfall;
    logic                wr_found, held_fall;
    logic [IDX_W-1:0]    wr_idx;

    assign wrise = key_state_reg & ~key_prev_reg;
    assign wfall = ~key_state_reg & key_prev_reg;

    always_comb begin
        wr_found  = 1'b0;
        wr_idx    = '0;
        held_fall = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (wrise[i]) begin
                wr_found = 1'b1;
                wr_idx   = IDX_W'(i);
            end
            if (IDX_W'(i) == wait_index_reg) begin
                held_fall = wfall[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_state_reg <= W_IDLE;
            wait_busy_reg  <= 1'b0;
            wait_done_reg  <= 1'b0;
            wait_index_reg <= '0;
            key_prev_reg   <= '0;
        end else begin
            key_prev_reg  <= key_state_reg;
            wait_done_reg <= 1'b0;
            case (wait_state_reg)
                W_IDLE: begin
                    if (wait_req) begin
                        wait_state_reg <= W_ARMED;
                        wait_busy_reg  <= 1'b1;
                    end
                end
                W_ARMED: begin
                    // In press mode the capture is the completion, so it
                    // still pulses when a re-arm arrives in the same cycle.
                    if (wr_found && WAIT_ON_RELEASE == 0) begin
                        wait_done_reg  <= 1'b1;
                        wait_index_reg <= wr_idx;
                    end
                    if (wait_req) begin
                        wait_state_reg <= W_ARMED;
                    end else if (wr_found) begin
                        if (WAIT_ON_RELEASE != 0) begin
                            wait_index_reg <= wr_idx;
                            wait_state_reg <= W_HELD;
                        end else begin
                            wait_state_reg <= W_IDLE;
                            wait_busy_reg  <= 1'b0;
                        end
                    end
                end
                W_HELD: begin
                    if (held_fall) begin
                        wait_done_reg <= 1'b1;
                    end
                    if (wait_req) begin
                        wait_state_reg <= W_ARMED;
                    end else if (held_fall) begin
                        wait_state_reg <= W_IDLE;
                        wait_busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    wait_state_reg <= W_IDLE;
                    wait_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign key_state    = key_state_reg;
    assign any_pressed  = any_pressed_reg;
    assign evt_valid    = evt_valid_reg;
    assign evt_index    = evt_index_reg;
    assign evt_is_press = evt_is_press_reg;
    assign wait_busy    = wait_busy_reg;
    assign wait_done    = wait_done_reg;
    assign wait_index   = wait_index_reg;
    assign overflow     = overflow_reg;

endmodule
